// File: rtl/main_and_gate.sv
// Glitch-filtered registered AND with edge pulses, coverage bits and a saturating rise counter; MAIN_AND_SYNC_EN selects a 2-flop synchronizer.
// Latency: input to v676ecb is 2+FILTER_LEN+1 cycles with MAIN_AND_SYNC_EN defined, otherwise 1+FILTER_LEN+1.
// Backpressure: none; the block samples every cycle and never stalls.
module main_and_gate #(
  parameter int FILTER_LEN = 4,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               va9742d,
  input  logic               va57306,
  input  logic               seen_clr,
  output logic               v676ecb,
  output logic               and_rise,
  output logic               and_fall,
  output logic [3:0]         seen,
  output logic [COUNT_W-1:0] rise_cnt
);

  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  logic       aCap, bCap;
  logic       aF, bF;
  logic [7:0] aCnt, bCnt;
  logic       andNow;

`ifdef MAIN_AND_SYNC_EN
  logic [1:0] aSync, bSync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSync <= 2'b00;
      bSync <= 2'b00;
    end else begin
      aSync <= {aSync[0], va9742d};
      bSync <= {bSync[0], va57306};
    end
  end

  assign aCap = aSync[1];
  assign bCap = bSync[1];
`else
  logic aReg, bReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg <= 1'b0;
      bReg <= 1'b0;
    end else begin
      aReg <= va9742d;
      bReg <= va57306;
    end
  end

  assign aCap = aReg;
  assign bCap = bReg;
`endif

  // A disagreement must persist FILTER_LEN consecutive cycles to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aF   <= 1'b0;
      aCnt <= 8'd0;
    end else if (aCap == aF) begin
      aCnt <= 8'd0;
    end else if (aCnt == FILT_LAST) begin
      aF   <= aCap;
      aCnt <= 8'd0;
    end else begin
      aCnt <= aCnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bF   <= 1'b0;
      bCnt <= 8'd0;
    end else if (bCap == bF) begin
      bCnt <= 8'd0;
    end else if (bCnt == FILT_LAST) begin
      bF   <= bCap;
      bCnt <= 8'd0;
    end else begin
      bCnt <= bCnt + 8'd1;
    end
  end

  assign andNow = aF & bF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v676ecb  <= 1'b0;
      and_rise <= 1'b0;
      and_fall <= 1'b0;
    end else begin
      v676ecb  <= andNow;
      and_rise <= andNow & ~v676ecb;
      and_fall <= ~andNow & v676ecb;
    end
  end

  // Clear takes priority; the live combination is re-marked next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= 4'b0000;
    end else if (seen_clr) begin
      seen <= 4'b0000;
    end else begin
      seen <= seen | (4'b0001 << {bF, aF});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
    end else if (and_rise && (rise_cnt != {COUNT_W{1'b1}})) begin
      rise_cnt <= rise_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_main_and_gate.sv
// Bench for main_and_gate: directed steps plus random input segments against a history-based reference model.
module tb_main_and_gate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       seenClr = 1'b0;

  logic       v0, r0, f0;
  logic [3:0] s0;
  logic [7:0] c0;
  logic       v1, r1, f1;
  logic [3:0] s1;
  logic [1:0] c1;

  int checks = 0;
  int errors = 0;

`ifdef MAIN_AND_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = 1 + SYNC + 4 + 1;

  main_and_gate #(.FILTER_LEN(4), .COUNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .va9742d(a), .va57306(b), .seen_clr(seenClr),
    .v676ecb(v0), .and_rise(r0), .and_fall(f0), .seen(s0), .rise_cnt(c0)
  );

  main_and_gate #(.FILTER_LEN(1), .COUNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .va9742d(a), .va57306(b), .seen_clr(seenClr),
    .v676ecb(v1), .and_rise(r1), .and_fall(f1), .seen(s1), .rise_cnt(c1)
  );

  always #5 clk = ~clk;

  // Reference model: captured-value history, and per-instance filtered state.
  bit [7:0] histA, histB;
  bit       inPrevA, inPrevB;
  bit       mAf [2];
  bit       mBf [2];
  bit       mV [2];
  bit       mRise [2];
  bit       mFall [2];
  bit [3:0] mSeen [2];
  int       mCnt [2];
  int       flen [2] = '{4, 1};
  int       cmax [2] = '{255, 3};

  int riseCount, fallCount, highCount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    histA = '0; histB = '0; inPrevA = 0; inPrevB = 0;
    for (int i = 0; i < 2; i++) begin
      mAf[i] = 0; mBf[i] = 0; mV[i] = 0; mRise[i] = 0; mFall[i] = 0;
      mSeen[i] = 4'b0000; mCnt[i] = 0;
    end
  endtask

  task automatic modelStep();
    bit capA, capB, flipA, flipB, andPrev;
    capA = (SYNC != 0) ? inPrevA : a;
    capB = (SYNC != 0) ? inPrevB : b;
    for (int i = 0; i < 2; i++) begin
      // Accept a new filtered value once the last flen captured samples all disagree.
      flipA = 1; flipB = 1;
      for (int j = 0; j < flen[i]; j++) begin
        if (histA[j] == mAf[i]) flipA = 0;
        if (histB[j] == mBf[i]) flipB = 0;
      end
      andPrev = mAf[i] & mBf[i];
      if (mRise[i] && mCnt[i] < cmax[i]) mCnt[i] = mCnt[i] + 1;
      mSeen[i] = seenClr ? 4'b0000 : (mSeen[i] | (4'b0001 << {mBf[i], mAf[i]}));
      mRise[i] = andPrev & ~mV[i];
      mFall[i] = ~andPrev & mV[i];
      mV[i]    = andPrev;
      mAf[i]   = mAf[i] ^ flipA;
      mBf[i]   = mBf[i] ^ flipB;
    end
    histA = {histA[6:0], capA};
    histB = {histB[6:0], capB};
    inPrevA = a;
    inPrevB = b;
  endtask

  task automatic compareAll();
    check("v676ecb[0]", v0, mV[0]);
    check("and_rise[0]", r0, mRise[0]);
    check("and_fall[0]", f0, mFall[0]);
    check("seen[0]", s0, mSeen[0]);
    check("rise_cnt[0]", c0, mCnt[0]);
    check("v676ecb[1]", v1, mV[1]);
    check("and_rise[1]", r1, mRise[1]);
    check("and_fall[1]", f1, mFall[1]);
    check("seen[1]", s1, mSeen[1]);
    check("rise_cnt[1]", c1, mCnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelStep();
    else modelReset();
    #1;
    compareAll();
    riseCount += int'(r0);
    fallCount += int'(f0);
    highCount += int'(v0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    #1;
    compareAll();
    check("reset_v676ecb", v0, 0);
    check("reset_seen", s0, 4'b0000);
    check("reset_rise_cnt", c0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic clearCounts();
    riseCount = 0; fallCount = 0; highCount = 0;
  endtask

  initial begin
    modelReset();
    clearCounts();
    @(posedge clk);
    #1;

    // Reset with both inputs high, then release and measure latency.
    a = 1; b = 1;
    doReset();
    clearCounts();
    repeat (LAT - 1) tick();
    check("latency_early", v0, 0);
    tick();
    check("latency_v676ecb", v0, 1);
    repeat (5) tick();
    check("reset_release_rises", riseCount, 1);

    // Truth table from a clean reset.
    a = 0; b = 0;
    doReset();
    for (int k = 0; k < 4; k++) begin
      a = (k >= 2);
      b = (k % 2 == 1);
      repeat (20) tick();
      check("truth_table", v0, (k == 3) ? 1 : 0);
    end
    check("truth_seen", s0, 4'b1111);
    check("truth_rise_cnt", c0, 1);

    // Glitch rejection on A with B held high.
    a = 0; b = 1;
    repeat (20) tick();
    clearCounts();
    a = 1;
    repeat (3) tick();
    a = 0;
    repeat (20) tick();
    check("glitch3_high", highCount, 0);
    check("glitch3_rise", riseCount, 0);
    clearCounts();
    a = 1;
    repeat (4) tick();
    a = 0;
    repeat (20) tick();
    check("glitch4_high", highCount, 4);
    check("glitch4_rise", riseCount, 1);
    check("glitch4_fall", fallCount, 1);
    check("glitch4_rise_cnt", c0, 2);

    // Coverage clear with A=B=1.
    a = 1; b = 1;
    repeat (20) tick();
    seenClr = 1;
    tick();
    check("seen_clr_zero", s0, 4'b0000);
    seenClr = 0;
    tick();
    check("seen_clr_remark", s0, 4'b1000);

    // Saturation of the 2-bit counter.
    a = 0; b = 1;
    doReset();
    repeat (10) tick();
    for (int p = 0; p < 5; p++) begin
      a = 1;
      repeat (8) tick();
      a = 0;
      repeat (8) tick();
      check("sat_rise_cnt", c1, (p < 3) ? p + 1 : 3);
    end

    // Random segments with varied hold lengths and occasional clears.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) a = 1'($urandom);
      if ($urandom_range(0, 3) == 0) b = 1'($urandom);
      seenClr = ($urandom_range(0, 15) == 0);
      tick();
    end
    seenClr = 0;

    // Asynchronous reset in the middle of a filter count.
    a = 0; b = 1;
    repeat (20) tick();
    a = 1;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    compareAll();
    check("async_v676ecb", v0, 0);
    check("async_seen", s0, 4'b0000);
    check("async_rise_cnt", c0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    check("async_latency_early", v0, 0);
    tick();
    check("async_latency_v676ecb", v0, 1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
